// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit
// Brief    : Iterative signed/unsigned multiply and divide producing HI/LO.
// Revision : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CALC  = 3'd1,
        S_FIX   = 3'd2,
        S_DONE  = 3'd3,
        S_DZERO = 3'd4
    } state_t;

    state_t r_state, w_next;

    logic [1:0]         r_op;
    logic               r_neg_a, r_neg_b;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_acc;   // product high half / partial remainder
    logic [WIDTH-1:0]   r_low;   // multiplier -> product low half / dividend -> quotient
    logic [WIDTH-1:0]   r_md;    // multiplicand / divisor magnitude

    logic               w_accept, w_sgn, w_a_neg, w_b_neg;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag;
    logic [WIDTH:0]     w_msum, w_dshift;
    logic [WIDTH-1:0]   w_dtrial;
    logic               w_dge;
    logic [2*WIDTH-1:0] w_prod, w_prod_n;
    logic               w_neg_res;
    logic [WIDTH-1:0]   w_fix_hi, w_fix_lo;

    // An unsigned WIDTH-bit magnitude holds |MIN_INT| exactly.
    assign w_sgn    = ~op[0];
    assign w_a_neg  = w_sgn & a[WIDTH-1];
    assign w_b_neg  = w_sgn & b[WIDTH-1];
    assign w_a_mag  = w_a_neg ? (~a + 1'b1) : a;
    assign w_b_mag  = w_b_neg ? (~b + 1'b1) : b;
    assign w_accept = start & ~busy;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        busy     = 1'b0;
        done     = 1'b0;
        div_zero = 1'b0;
        case (r_state)
            S_IDLE, S_DONE, S_DZERO: begin
                done     = (r_state != S_IDLE);
                div_zero = (r_state == S_DZERO);
                if (start)
                    w_next = (op[1] && (b == '0)) ? S_DZERO : S_CALC;
                else
                    w_next = S_IDLE;
            end
            S_CALC: begin
                busy = 1'b1;
                if (r_cnt == c_LAST) w_next = S_FIX;
            end
            S_FIX: begin
                busy   = 1'b1;
                w_next = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // One shift-add step: sum carries into the bit shifted down into r_acc.
    assign w_msum   = {1'b0, r_acc} + (r_low[0] ? {1'b0, r_md} : '0);
    // One restoring-division step.
    assign w_dshift = {r_acc, r_low[WIDTH-1]};
    assign w_dge    = (w_dshift >= {1'b0, r_md});
    assign w_dtrial = w_dshift[WIDTH-1:0] - r_md;

    assign w_prod    = {r_acc, r_low};
    assign w_prod_n  = ~w_prod + 1'b1;
    assign w_neg_res = ~r_op[0] & (r_neg_a ^ r_neg_b);

    always_comb begin
        w_fix_hi = r_acc;
        w_fix_lo = r_low;
        if (r_op[1]) begin
            if (w_neg_res)            w_fix_lo = ~r_low + 1'b1;
            if (~r_op[0] & r_neg_a)   w_fix_hi = ~r_acc + 1'b1;
        end else if (w_neg_res) begin
            {w_fix_hi, w_fix_lo} = w_prod_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op    <= '0;
            r_neg_a <= 1'b0;
            r_neg_b <= 1'b0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_low   <= '0;
            r_md    <= '0;
            hi      <= '0;
            lo      <= '0;
        end else if (w_accept) begin
            r_op    <= op;
            r_neg_a <= w_a_neg;
            r_neg_b <= w_b_neg;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_md    <= op[1] ? w_b_mag : w_a_mag;
            r_low   <= op[1] ? w_a_mag : w_b_mag;
        end else if (r_state == S_CALC) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_op[1]) begin
                r_acc <= w_dge ? w_dtrial : w_dshift[WIDTH-1:0];
                r_low <= {r_low[WIDTH-2:0], w_dge};
            end else begin
                r_acc <= w_msum[WIDTH:1];
                r_low <= {w_msum[0], r_low[WIDTH-1:1]};
            end
        end else if (r_state == S_FIX) begin
            hi <= w_fix_hi;
            lo <= w_fix_lo;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_div_unit
// Brief    : Scoreboard bench for mult_div_unit (WIDTH=32) with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          cyc;
        int          id;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    int   dones = 0;
    int   next_id = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s v%0d: got 0x%08h expected 0x%08h", name, id, act, req);
        end
    endtask

    // Monitor: the current cycle at a negedge is the one ending at the next posedge.
    always @(negedge clk) begin
        if (!reset && done) begin
            exp_t e;
            dones++;
            if (q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_done: got done=1 expected done=0 at cycle %0d", cyc + 1);
            end else begin
                e = q.pop_front();
                chk("hi",       e.id, hi, e.hi);
                chk("lo",       e.id, lo, e.lo);
                chk("div_zero", e.id, {31'd0, div_zero}, {31'd0, e.dz});
                chk("done_cycle", e.id, cyc + 1, e.cyc);
            end
        end
    end

    task automatic push_exp(input int t, input logic [31:0] eh, input logic [31:0] el, input logic edz);
        exp_t e;
        e.hi = eh; e.lo = el; e.dz = edz;
        e.cyc = t + (edz ? 1 : 34);
        e.id = next_id++;
        q.push_back(e);
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] ia, input logic [31:0] ib,
                         input logic [31:0] eh, input logic [31:0] el, input logic edz);
        @(negedge clk);
        start = 1'b1; op = o; a = ia; b = ib;
        push_exp(cyc + 1, eh, el, edz);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dn;
        reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy",  -1, {31'd0, busy},     32'd0);
        chk("rst_done",  -1, {31'd0, done},     32'd0);
        chk("rst_dz",    -1, {31'd0, div_zero}, 32'd0);
        chk("rst_hi",    -1, hi, 32'd0);
        chk("rst_lo",    -1, lo, 32'd0);
        reset = 1'b0;

        issue(2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0); drain();
        issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0); drain();
        issue(2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0); drain();
        issue(2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0); drain();
        issue(2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0); drain();
        issue(2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0); drain();
        issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0); drain();
        issue(2'b11, 32'd95,       32'd10,       32'd5,        32'd9,        1'b0); drain();
        issue(2'b11, 32'd1234,     32'd0,        32'd5,        32'd9,        1'b1); drain();
        issue(2'b10, 32'hFFFFFFFB, 32'd0,        32'd5,        32'd9,        1'b1); drain();

        // A start pulse in CALC cycle 5 must not disturb the latched operands.
        issue(2'b01, 32'h12345678, 32'h10, 32'h00000001, 32'h23456780, 1'b0);
        repeat (4) @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
        @(negedge clk);
        start = 1'b0;
        drain();

        // start held through the done cycle chains a second op with no gap.
        issue(2'b11, 32'd1000, 32'd3, 32'd1, 32'd333, 1'b0);
        start = 1'b1; op = 2'b00; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
        for (int i = 0; i < 100 && !done; i++) @(negedge clk);
        push_exp(cyc + 1, 32'h00000000, 32'h00000001, 1'b0);
        @(negedge clk);
        start = 1'b0;
        drain();

        // Reset in CALC cycle 10 aborts without a done pulse and clears hi/lo.
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'd5; b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", -1, {31'd0, busy}, 32'd0);
        chk("abort_hi",   -1, hi, 32'd0);
        chk("abort_lo",   -1, lo, 32'd0);
        reset = 1'b0;
        dn = dones;
        repeat (40) @(negedge clk);
        chk("abort_no_done", -1, dones, dn);

        checks++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL leftover: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
